// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner: synchronizes, debounces and times raw push-buttons,
// producing single-cycle press/release/long-press pulses and a held level.
module key_pulse_conditioner #(
    parameter int unsigned N_KEYS            = 3,
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter int unsigned ACTIVE_LOW        = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_keys,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_held
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LONG_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic        RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_UP     = 2'd0,
        S_UP_CHK = 2'd1,
        S_DN     = 2'd2,
        S_DN_CHK = 2'd3
    } key_state_e;

    for (genvar k = 0; k < int'(N_KEYS); k++) begin : g_key
        logic              sync1_q;
        logic              sync2_q;
        logic              pressed;
        key_state_e        state_q;
        logic [DEB_W-1:0]  deb_q;
        logic [LONG_W-1:0] timer_q;
        logic              long_done_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              held_q;
        logic              accept_press;
        logic              in_dn;

        // Two-flop synchronizer, reset to the unpressed raw level
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync1_q <= RAW_IDLE;
                sync2_q <= RAW_IDLE;
            end else begin
                sync1_q <= i_keys[k];
                sync2_q <= sync1_q;
            end
        end

        assign pressed      = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
        assign accept_press = (state_q == S_UP_CHK) && pressed && (deb_q == DEB_LAST);
        assign in_dn        = (state_q == S_DN) || (state_q == S_DN_CHK);

        // Debounce FSM with registered press/release pulses and held level
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q   <= S_UP;
                deb_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    S_UP: begin
                        if (pressed) begin
                            state_q <= S_UP_CHK;
                            deb_q   <= DEB_W'(1);
                        end
                    end
                    S_UP_CHK: begin
                        if (!pressed) begin
                            state_q <= S_UP;
                            deb_q   <= '0;
                        end else if (deb_q == DEB_LAST) begin
                            state_q <= S_DN;
                            deb_q   <= '0;
                            press_q <= 1'b1;
                            held_q  <= 1'b1;
                        end else begin
                            deb_q <= deb_q + DEB_W'(1);
                        end
                    end
                    S_DN: begin
                        if (!pressed) begin
                            state_q <= S_DN_CHK;
                            deb_q   <= DEB_W'(1);
                        end
                    end
                    S_DN_CHK: begin
                        if (pressed) begin
                            state_q <= S_DN;
                            deb_q   <= '0;
                        end else if (deb_q == DEB_LAST) begin
                            state_q   <= S_UP;
                            deb_q     <= '0;
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end else begin
                            deb_q <= deb_q + DEB_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_UP;
                        deb_q   <= '0;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end

        // Long-press timer: cleared on press, saturates, fires at most once per hold
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                timer_q     <= '0;
                long_done_q <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (accept_press) begin
                    timer_q     <= '0;
                    long_done_q <= 1'b0;
                end else if (in_dn) begin
                    if (timer_q != LONG_LAST) begin
                        timer_q <= timer_q + LONG_W'(1);
                    end else if (!long_done_q) begin
                        long_q      <= 1'b1;
                        long_done_q <= 1'b1;
                    end
                end
            end
        end

        assign o_press[k]   = press_q;
        assign o_release[k] = release_q;
        assign o_long[k]    = long_q;
        assign o_held[k]    = held_q;
    end

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner (DEBOUNCE=4, LONG=20, active-low keys).
module tb_key_pulse_conditioner;

    logic       clk;
    logic       rst_n;
    logic [2:0] keys;
    logic [2:0] o_press;
    logic [2:0] o_release;
    logic [2:0] o_long;
    logic [2:0] o_held;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] keys;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] lng;
        logic [2:0] held;
    } vec_t;

    vec_t tbl [18];

    key_pulse_conditioner #(
        .N_KEYS           (3),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .ACTIVE_LOW       (1)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_keys   (keys),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long),
        .o_held   (o_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ep, input logic [2:0] er,
                           input logic [2:0] el, input logic [2:0] eh);
        chk({tag, ".press"},   o_press,   ep);
        chk({tag, ".release"}, o_release, er);
        chk({tag, ".long"},    o_long,    el);
        chk({tag, ".held"},    o_held,    eh);
    endtask

    initial begin
        logic [2:0] ep, er, eh;
        int rel_t [3];

        // Clean press/release on key0: press accepted 5 edges after the first capture edge
        for (int i = 0; i < 5; i++)   tbl[i] = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[5] = '{3'b110, 3'b001, 3'b000, 3'b000, 3'b001};
        for (int i = 6; i < 10; i++)  tbl[i] = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b001};
        for (int i = 10; i < 15; i++) tbl[i] = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b001};
        tbl[15] = '{3'b111, 3'b000, 3'b001, 3'b000, 3'b000};
        for (int i = 16; i < 18; i++) tbl[i] = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b000};

        // Reset state
        rst_n = 1'b0;
        keys  = 3'b111;
        #2;
        chk_all("reset", 3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        tick();
        chk_all("reset_hold", 3'b000, 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk_all("idle", 3'b000, 3'b000, 3'b000, 3'b000);
        end

        // Table-driven clean press and release
        for (int i = 0; i < 18; i++) begin
            keys = tbl[i].keys;
            tick();
            chk_all($sformatf("tbl%0d", i), tbl[i].press, tbl[i].rel, tbl[i].lng, tbl[i].held);
        end

        // Bounce rejection on key1
        for (int c = 0; c < 30; c++) begin
            keys = (((c / 2) % 2) == 0) ? 3'b101 : 3'b111;
            tick();
            chk_all("bounce", 3'b000, 3'b000, 3'b000, 3'b000);
        end
        keys = 3'b111;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_all("bounce_settle", 3'b000, 3'b000, 3'b000, 3'b000);
        end

        // Long press on key2: press at 5, long exactly 20 cycles later, once
        for (int c = 0; c < 40; c++) begin
            keys = 3'b011;
            tick();
            chk_all("long_hold", (c == 5) ? 3'b100 : 3'b000, 3'b000,
                    (c == 25) ? 3'b100 : 3'b000, (c >= 5) ? 3'b100 : 3'b000);
        end
        for (int c = 0; c < 10; c++) begin
            keys = 3'b111;
            tick();
            chk_all("long_rel", 3'b000, (c == 5) ? 3'b100 : 3'b000, 3'b000,
                    (c < 5) ? 3'b100 : 3'b000);
        end

        // Simultaneous press, staggered releases (key0 at 8, key1 at 10, key2 at 12)
        rel_t[0] = 8;
        rel_t[1] = 10;
        rel_t[2] = 12;
        for (int c = 0; c < 23; c++) begin
            for (int k = 0; k < 3; k++) keys[k] = (c >= rel_t[k]) ? 1'b1 : 1'b0;
            tick();
            ep = (c == 5) ? 3'b111 : 3'b000;
            for (int k = 0; k < 3; k++) begin
                er[k] = (c == rel_t[k] + 5) ? 1'b1 : 1'b0;
                eh[k] = (c >= 5 && c < rel_t[k] + 5) ? 1'b1 : 1'b0;
            end
            chk_all("simul", ep, er, 3'b000, eh);
        end

        // Reset while key0 is held: full debounce again, exactly one press
        for (int c = 0; c < 10; c++) begin
            keys = 3'b110;
            tick();
            chk_all("pre_rst", (c == 5) ? 3'b001 : 3'b000, 3'b000, 3'b000,
                    (c >= 5) ? 3'b001 : 3'b000);
        end
        rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk_all("post_rst", (c == 5) ? 3'b001 : 3'b000, 3'b000, 3'b000,
                    (c >= 5) ? 3'b001 : 3'b000);
        end
        for (int c = 0; c < 10; c++) begin
            keys = 3'b111;
            tick();
            chk_all("post_rst_rel", 3'b000, (c == 5) ? 3'b001 : 3'b000, 3'b000,
                    (c < 5) ? 3'b001 : 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
